// File: rtl/lsq_pkg.sv
// Shared types and constants for the LSQ retire bundle buffer.
//   lsq_bundle_t : one retire bundle (II, slot mask, slot indices, exception info,
//                  wait/load conflict flags and the shared payload).
//   LSQ_SLOTS    : memory-op slots per bundle.
//   LSQ_II_IDLE  : II presented downstream when no bundle is queued.
`ifndef LSQSHARE_WIDTH
`define LSQSHARE_WIDTH 16
`endif

package lsq_pkg;

  localparam int unsigned LSQ_SLOTS   = 6;
  localparam logic [5:0]  LSQ_II_IDLE = 6'h3f;
  // Widest shared payload an entry can hold; the top zero-extends narrower payloads.
  localparam int unsigned LSQ_SHR_W   = `LSQSHARE_WIDTH;

  typedef struct packed {
    logic [5:0]             ii;
    logic [LSQ_SLOTS-1:0]   mask;
    logic [4*LSQ_SLOTS-1:0] slot_ii;
    logic [LSQ_SLOTS-1:0]   excpt;
    logic [4*LSQ_SLOTS-1:0] exbits;
    logic [LSQ_SLOTS-1:0]   wait_confl;
    logic [LSQ_SLOTS-1:0]   ld_confl;
    logic [LSQ_SHR_W-1:0]   shr;
  } lsq_bundle_t;

endpackage

// File: rtl/lsq_bundle_entry.sv
// One retire-bundle slot of the buffer.
// Ports:
//   clk_i, rst_i        : clock, async active-high reset
//   flush_i             : thread flush, drops the entry
//   push_i, wr_data_i   : load a new bundle (unsealed, ld_confl already cleared)
//   pop_i               : entry leaves from the head
//   upd_*_i             : conflict update broadcast, matched by II
//   valid_o, sealed_o   : entry state
//   data_o              : stored bundle
module lsq_bundle_entry
  import lsq_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 push_i,
  input  lsq_bundle_t          wr_data_i,
  input  logic                 pop_i,
  input  logic                 upd_en_i,
  input  logic [5:0]           upd_ii_i,
  input  logic [LSQ_SLOTS-1:0] upd_ld_confl_i,
  input  logic                 upd_seal_i,
  output logic                 valid_o,
  output logic                 sealed_o,
  output lsq_bundle_t          data_o
);

  logic        valid_q, valid_d;
  logic        sealed_q, sealed_d;
  lsq_bundle_t data_q, data_d;

  always_comb begin
    valid_d  = valid_q;
    sealed_d = sealed_q;
    data_d   = data_q;
    if (flush_i) begin
      valid_d  = 1'b0;
      sealed_d = 1'b0;
    end else begin
      if (pop_i) begin
        valid_d  = 1'b0;
        sealed_d = 1'b0;
      end
      // Push wins over pop: a full buffer reuses the head slot in the same cycle.
      if (push_i) begin
        valid_d  = 1'b1;
        sealed_d = 1'b0;
        data_d   = wr_data_i;
      end
      // Match against the post-push contents so a same-cycle update reaches a new bundle.
      if (upd_en_i && valid_d && (data_d.ii == upd_ii_i)) begin
        data_d.ld_confl = data_d.ld_confl | upd_ld_confl_i;
        if (upd_seal_i) begin
          sealed_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q  <= 1'b0;
      sealed_q <= 1'b0;
      data_q   <= '0;
    end else begin
      valid_q  <= valid_d;
      sealed_q <= sealed_d;
      data_q   <= data_d;
    end
  end

  assign valid_o  = valid_q;
  assign sealed_o = sealed_q;
  assign data_o   = data_q;

endmodule

// File: rtl/lsq_ret_bundle_buf.sv
// Per-thread FIFO of load/store retire bundles feeding the LSQ retire-decision stage.
// Ports:
//   clk, rst                 : clock, async active-high reset
//   wr_*                     : bundle push
//   upd_*                    : late load-conflict merge / seal, matched by II
//   dataB_*                  : head bundle; dataB_enOut pops it when dataB_ready
//   except, except_thread    : flush of this thread's contents
//   wr_full, count, ovf      : occupancy status; ovf is sticky on a dropped push
`ifndef LSQSHARE_WIDTH
`define LSQSHARE_WIDTH 16
`endif

module lsq_ret_bundle_buf
  import lsq_pkg::*;
#(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned SHR_WIDTH = `LSQSHARE_WIDTH,
  parameter int unsigned THREAD    = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [5:0]                 wr_II,
  input  logic [5:0]                 wr_mask,
  input  logic [23:0]                wr_slotII,
  input  logic [5:0]                 wr_excpt,
  input  logic [23:0]                wr_exbits,
  input  logic [5:0]                 wr_wait_confl,
  input  logic [SHR_WIDTH-1:0]       wr_shr,
  input  logic                       upd_en,
  input  logic [5:0]                 upd_II,
  input  logic [5:0]                 upd_ld_confl,
  input  logic                       upd_seal,
  output logic [5:0]                 dataB_ret_mask,
  output logic [5:0]                 dataB_ld_confl,
  output logic [5:0]                 dataB_wait_confl,
  output logic [5:0]                 dataB_excpt,
  output logic [23:0]                dataB_exbits,
  output logic [5:0]                 dataB_II,
  output logic [3:0]                 dataB_II0,
  output logic [3:0]                 dataB_II1,
  output logic [3:0]                 dataB_II2,
  output logic [3:0]                 dataB_II3,
  output logic [3:0]                 dataB_II4,
  output logic [3:0]                 dataB_II5,
  output logic [SHR_WIDTH-1:0]       dataB_data_shr,
  output logic                       dataB_thread,
  output logic                       dataB_ready,
  input  logic                       dataB_enOut,
  input  logic                       except,
  input  logic                       except_thread,
  output logic                       wr_full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       ovf
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic        ThreadBit = 1'(THREAD);
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;
  logic            full_q, full_d;
  logic            ovf_q, ovf_d;

  logic [DEPTH-1:0] ent_valid;
  logic [DEPTH-1:0] ent_sealed;
  lsq_bundle_t      ent_data [DEPTH];

  lsq_bundle_t wr_bundle;
  lsq_bundle_t head_data;
  logic        head_valid;
  logic        flush;
  logic        pop;
  logic        push;

  assign flush      = except && (except_thread == ThreadBit);
  assign head_valid = ent_valid[head_q];
  assign head_data  = ent_data[head_q];
  assign dataB_ready = head_valid && ent_sealed[head_q];

  assign pop  = dataB_enOut && dataB_ready && !flush;
  // A pop in the same cycle frees the slot even when full.
  assign push = wr_en && ((count_q < DepthCnt) || pop) && !flush;

  always_comb begin
    wr_bundle            = '0;
    wr_bundle.ii         = wr_II;
    wr_bundle.mask       = wr_mask;
    wr_bundle.slot_ii    = wr_slotII;
    wr_bundle.excpt      = wr_excpt;
    wr_bundle.exbits     = wr_exbits;
    wr_bundle.wait_confl = wr_wait_confl;
    wr_bundle.ld_confl   = '0;
    wr_bundle.shr        = LSQ_SHR_W'(wr_shr);
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    lsq_bundle_entry u_entry (
      .clk_i          (clk),
      .rst_i          (rst),
      .flush_i        (flush),
      .push_i         (push && (tail_q == PtrW'(i))),
      .wr_data_i      (wr_bundle),
      .pop_i          (pop && (head_q == PtrW'(i))),
      .upd_en_i       (upd_en),
      .upd_ii_i       (upd_II),
      .upd_ld_confl_i (upd_ld_confl),
      .upd_seal_i     (upd_seal),
      .valid_o        (ent_valid[i]),
      .sealed_o       (ent_sealed[i]),
      .data_o         (ent_data[i])
    );
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // Pointer widths equal log2(DEPTH), so the increment wraps naturally.
      if (push) tail_d = tail_q + PtrW'(1);
      if (pop)  head_d = head_q + PtrW'(1);
      count_d = count_q + CntW'(push) - CntW'(pop);
      if (wr_en && !push) ovf_d = 1'b1;
    end
    full_d = (count_d == DepthCnt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      full_q  <= full_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    dataB_II         = LSQ_II_IDLE;
    dataB_ret_mask   = '0;
    dataB_ld_confl   = '0;
    dataB_wait_confl = '0;
    dataB_excpt      = '0;
    dataB_exbits     = '0;
    dataB_II0        = '0;
    dataB_II1        = '0;
    dataB_II2        = '0;
    dataB_II3        = '0;
    dataB_II4        = '0;
    dataB_II5        = '0;
    dataB_data_shr   = '0;
    if (head_valid) begin
      dataB_II         = head_data.ii;
      dataB_ret_mask   = head_data.mask;
      dataB_ld_confl   = head_data.ld_confl;
      dataB_wait_confl = head_data.wait_confl;
      dataB_excpt      = head_data.excpt;
      dataB_exbits     = head_data.exbits;
      dataB_II0        = head_data.slot_ii[3:0];
      dataB_II1        = head_data.slot_ii[7:4];
      dataB_II2        = head_data.slot_ii[11:8];
      dataB_II3        = head_data.slot_ii[15:12];
      dataB_II4        = head_data.slot_ii[19:16];
      dataB_II5        = head_data.slot_ii[23:20];
      dataB_data_shr   = head_data.shr[SHR_WIDTH-1:0];
    end
  end

  assign dataB_thread = ThreadBit;
  assign wr_full      = full_q;
  assign count        = count_q;
  assign ovf          = ovf_q;

endmodule

// File: tb/tb_lsq_ret_bundle_buf.sv
module tb_lsq_ret_bundle_buf;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned SHRW  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wr_en = 1'b0;
  logic [5:0] wr_II = '0, wr_mask = '0, wr_excpt = '0, wr_wait_confl = '0;
  logic [23:0] wr_slotII = '0, wr_exbits = '0;
  logic [SHRW-1:0] wr_shr = '0;
  logic upd_en = 1'b0, upd_seal = 1'b0;
  logic [5:0] upd_II = '0, upd_ld_confl = '0;
  logic dataB_enOut = 1'b0, except = 1'b0, except_thread = 1'b0;

  logic [5:0] dataB_ret_mask, dataB_ld_confl, dataB_wait_confl, dataB_excpt, dataB_II;
  logic [23:0] dataB_exbits;
  logic [3:0] dataB_II0, dataB_II1, dataB_II2, dataB_II3, dataB_II4, dataB_II5;
  logic [SHRW-1:0] dataB_data_shr;
  logic dataB_thread, dataB_ready, wr_full, ovf;
  logic [3:0] count;

  int n_checks = 0;
  int n_fail   = 0;

  lsq_ret_bundle_buf #(.DEPTH(DEPTH), .SHR_WIDTH(SHRW), .THREAD(0)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_II(wr_II), .wr_mask(wr_mask),
    .wr_slotII(wr_slotII), .wr_excpt(wr_excpt), .wr_exbits(wr_exbits),
    .wr_wait_confl(wr_wait_confl), .wr_shr(wr_shr), .upd_en(upd_en), .upd_II(upd_II),
    .upd_ld_confl(upd_ld_confl), .upd_seal(upd_seal), .dataB_ret_mask(dataB_ret_mask),
    .dataB_ld_confl(dataB_ld_confl), .dataB_wait_confl(dataB_wait_confl),
    .dataB_excpt(dataB_excpt), .dataB_exbits(dataB_exbits), .dataB_II(dataB_II),
    .dataB_II0(dataB_II0), .dataB_II1(dataB_II1), .dataB_II2(dataB_II2),
    .dataB_II3(dataB_II3), .dataB_II4(dataB_II4), .dataB_II5(dataB_II5),
    .dataB_data_shr(dataB_data_shr), .dataB_thread(dataB_thread),
    .dataB_ready(dataB_ready), .dataB_enOut(dataB_enOut), .except(except),
    .except_thread(except_thread), .wr_full(wr_full), .count(count), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic [5:0] wii;
    logic [5:0] wmask;
    logic       upd;
    logic [5:0] uii;
    logic [5:0] ucf;
    logic       seal;
    logic       pop;
    logic       exc;
    logic       exth;
    logic [3:0] e_cnt;
    logic       e_rdy;
    logic [5:0] e_ii;
    logic [5:0] e_cf;
    logic [5:0] e_mask;
    logic       e_full;
    logic       e_ovf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic wr, logic [5:0] wii, logic [5:0] wmask, logic upd,
                              logic [5:0] uii, logic [5:0] ucf, logic seal, logic pop,
                              logic exc, logic exth, logic [3:0] e_cnt, logic e_rdy,
                              logic [5:0] e_ii, logic [5:0] e_cf, logic [5:0] e_mask,
                              logic e_full, logic e_ovf);
    vec_t v;
    v.wr = wr; v.wii = wii; v.wmask = wmask; v.upd = upd; v.uii = uii; v.ucf = ucf;
    v.seal = seal; v.pop = pop; v.exc = exc; v.exth = exth; v.e_cnt = e_cnt;
    v.e_rdy = e_rdy; v.e_ii = e_ii; v.e_cf = e_cf; v.e_mask = e_mask;
    v.e_full = e_full; v.e_ovf = e_ovf;
    return v;
  endfunction

  // Side fields of a pushed bundle are derived from its II so the head can be checked.
  function automatic logic [23:0] slot_of(logic [5:0] ii);
    logic [23:0] s;
    for (int k = 0; k < 6; k++) s[4*k +: 4] = ii[3:0] + 4'(k);
    return s;
  endfunction

  task automatic chk(string name, int unsigned act, int unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    wr_en = 0; upd_en = 0; upd_seal = 0; dataB_enOut = 0; except = 0; except_thread = 0;
    wr_II = 0; wr_mask = 0; upd_II = 0; upd_ld_confl = 0;
  endtask

  task automatic drive_push(logic [5:0] ii, logic [5:0] mask);
    wr_en = 1; wr_II = ii; wr_mask = mask; wr_slotII = slot_of(ii);
    wr_excpt = ~ii; wr_exbits = {4{ii}}; wr_wait_confl = ii ^ 6'h2a;
    wr_shr = {ii[3:0], 6'h15, ii};
  endtask

  task automatic drive_upd(logic [5:0] ii, logic [5:0] cf, logic seal);
    upd_en = 1; upd_II = ii; upd_ld_confl = cf; upd_seal = seal;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    #12 rst = 0;
    @(negedge clk);

    chk("reset count", count, 0);
    chk("reset II", dataB_II, 6'h3f);
    chk("reset ready", dataB_ready, 0);
    chk("reset full", wr_full, 0);
    chk("reset ovf", ovf, 0);
    chk("thread", dataB_thread, 0);

    //         wr wii  wmask upd uii ucf seal pop exc exth cnt rdy ii  cf  mask full ovf
    vecs.push_back(mk(1, 5, 6'h03, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5, 0, 6'h03, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5, 0, 6'h03, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 5, 6'h02, 1, 0, 0, 0, 1, 1, 5, 6'h02, 6'h03, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 6'h3f, 0, 0, 0, 0));
    vecs.push_back(mk(1, 9, 6'h3f, 1, 9, 6'h3f, 1, 0, 0, 0, 1, 1, 9, 6'h3f, 6'h3f, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 6'h3f, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 6'h3f, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 6'h01, 0, 0, 0, 0, 1, 0, 0, 1, 0, 1, 0, 6'h01, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 7, 6'h3f, 1, 0, 0, 0, 1, 0, 1, 0, 6'h01, 0, 0));
    vecs.push_back(mk(1, 2, 6'h01, 0, 0, 0, 0, 0, 0, 0, 2, 0, 1, 0, 6'h01, 0, 0));
    vecs.push_back(mk(1, 3, 6'h01, 0, 0, 0, 0, 0, 0, 0, 3, 0, 1, 0, 6'h01, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 3, 0, 1, 0, 6'h01, 0, 0));
    vecs.push_back(mk(1, 4, 6'h01, 1, 1, 6'h01, 1, 0, 1, 0, 0, 0, 6'h3f, 0, 0, 0, 0));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1, 6'(i), 6'h3f, 0, 0, 0, 0, 0, 0, 0, 4'(i + 1), 0, 0, 0, 6'h3f,
                        (i == 7), 0));
    vecs.push_back(mk(1, 8, 6'h3f, 0, 0, 0, 0, 0, 0, 0, 8, 0, 0, 0, 6'h3f, 1, 1));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 8, 1, 0, 0, 6'h3f, 1, 1));
    vecs.push_back(mk(1, 8, 6'h3f, 0, 0, 0, 0, 1, 0, 0, 8, 0, 1, 0, 6'h3f, 1, 1));

    foreach (vecs[n]) begin
      idle();
      if (vecs[n].wr) drive_push(vecs[n].wii, vecs[n].wmask);
      if (vecs[n].upd) drive_upd(vecs[n].uii, vecs[n].ucf, vecs[n].seal);
      dataB_enOut = vecs[n].pop;
      except = vecs[n].exc;
      except_thread = vecs[n].exth;
      step();
      chk($sformatf("v%0d count", n), count, vecs[n].e_cnt);
      chk($sformatf("v%0d ready", n), dataB_ready, vecs[n].e_rdy);
      chk($sformatf("v%0d II", n), dataB_II, vecs[n].e_ii);
      chk($sformatf("v%0d ld_confl", n), dataB_ld_confl, vecs[n].e_cf);
      chk($sformatf("v%0d mask", n), dataB_ret_mask, vecs[n].e_mask);
      chk($sformatf("v%0d full", n), wr_full, vecs[n].e_full);
      chk($sformatf("v%0d ovf", n), ovf, vecs[n].e_ovf);
    end

    // Drain: head order must be 1..8, with the replacement bundle 8 at the tail.
    for (int k = 1; k <= 8; k++) begin
      idle();
      drive_upd(6'(k), 0, 1);
      step();
      chk($sformatf("drain%0d ready", k), dataB_ready, 1);
      chk($sformatf("drain%0d II", k), dataB_II, k);
      if (k == 8) begin
        chk("side slotII", {dataB_II5, dataB_II4, dataB_II3, dataB_II2, dataB_II1,
                            dataB_II0}, slot_of(6'd8));
        chk("side excpt", dataB_excpt, 6'h37);
        chk("side exbits", dataB_exbits, 24'h208208);
        chk("side wait", dataB_wait_confl, 6'h22);
        chk("side shr", dataB_data_shr, {4'h8, 6'h15, 6'h08});
      end
      idle();
      dataB_enOut = 1;
      step();
    end
    chk("drain count", count, 0);
    chk("drain full", wr_full, 0);
    chk("drain II", dataB_II, 6'h3f);

    // Wrap: push+seal and pop every cycle across several pointer wraps.
    idle();
    drive_push(0, 6'h01);
    drive_upd(0, 0, 1);
    step();
    chk("wrap0 ready", dataB_ready, 1);
    chk("wrap0 II", dataB_II, 0);
    for (int i = 1; i <= 20; i++) begin
      idle();
      drive_push(6'(i), 6'h01);
      drive_upd(6'(i), 0, 1);
      dataB_enOut = 1;
      step();
      chk($sformatf("wrap%0d II", i), dataB_II, i);
      chk($sformatf("wrap%0d ready", i), dataB_ready, 1);
      chk($sformatf("wrap%0d count", i), count, 1);
    end

    // Own-thread flush leaves ovf alone.
    for (int i = 21; i <= 23; i++) begin
      idle();
      drive_push(6'(i), 6'h01);
      step();
    end
    chk("preflush count", count, 4);
    idle();
    except = 1;
    step();
    chk("flush count", count, 0);
    chk("flush ovf", ovf, 1);
    chk("flush II", dataB_II, 6'h3f);

    // Async reset mid-cycle with 4 entries held.
    for (int i = 30; i <= 33; i++) begin
      idle();
      drive_push(6'(i), 6'h01);
      drive_upd(6'(i), 0, 1);
      step();
    end
    idle();
    chk("prerst count", count, 4);
    #2 rst = 1;
    #1;
    chk("rst count", count, 0);
    chk("rst II", dataB_II, 6'h3f);
    chk("rst ovf", ovf, 0);
    chk("rst ready", dataB_ready, 0);
    @(negedge clk);
    rst = 0;
    step();
    chk("postrst count", count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

endmodule
